// File: rtl/quad_pkg.sv
// Shared constants, step encoding and transition decode for the quadrature decoder.
package quad_pkg;

  localparam int POS_W_DEF    = 10;
  localparam int FILT_LEN_DEF = 3;
  localparam int VEL_WIN_DEF  = 1024;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_t;

  // Gray sequence 00 -> 01 -> 11 -> 10 -> 00 is forward; both bits flipping is illegal.
  function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    step_t s;
    case ({prev_ab, cur_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: s = STEP_REV;
      4'b0000, 4'b0101, 4'b1111, 4'b1010: s = STEP_NONE;
      default:                            s = STEP_ERR;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One-bit 2-flop synchronizer followed by a consecutive-cycle glitch filter.
// After reset the filter first locks onto whatever level is stable for
// FILT_LEN cycles and raises valid; from then on a new level is accepted
// once the synchronized input has differed for FILT_LEN consecutive cycles.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic valid
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILT_LEN);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q, filt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for synchronizer chain and filter counter.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!valid_q) begin
      // Initial lock: filt_q holds the candidate level being timed.
      if (sync2_q != filt_q) begin
        filt_d = sync2_q;
        cnt_d  = CNT_W'(1);
      end else if (cnt_q == CNT_TC) begin
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (cnt_q == CNT_TC) begin
      filt_d = ~filt_q;
      cnt_d  = '0;
    end else if (sync2_q != filt_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout  = filt_q;
  assign valid = valid_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: filtered A/B/Z inputs, wrapping position counter
// with clear/index load, illegal-transition tracking and windowed velocity.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int POS_W    = POS_W_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int VEL_WIN  = VEL_WIN_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    enc_z,
  input  logic                    clear,
  output logic [POS_W-1:0]        position,
  output logic                    dir,
  output logic                    step_valid,
  output logic                    step_err,
  output logic [7:0]              err_count,
  output logic signed [POS_W:0]   velocity,
  output logic                    vel_valid
);

  localparam int WIN_W   = $clog2(VEL_WIN);
  localparam int ACC_RAW = $clog2(VEL_WIN + 1) + 1;
  localparam int ACC_W   = (ACC_RAW > POS_W + 1) ? ACC_RAW : POS_W + 1;
  localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(VEL_WIN - 1);
  localparam logic signed [ACC_W-1:0] VEL_MAX  = ACC_W'((2 ** POS_W) - 1);
  localparam logic signed [ACC_W-1:0] VEL_MIN  = ~VEL_MAX;

  logic a_f, b_f, z_f;
  logic a_v, b_v, z_v;

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .din(enc_a), .dout(a_f), .valid(a_v)
  );
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .din(enc_b), .dout(b_f), .valid(b_v)
  );
  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
    .clk(clk), .reset(reset), .din(enc_z), .dout(z_f), .valid(z_v)
  );

  logic [1:0]              prev_ab_q, prev_ab_d;
  logic                    prev_z_q, prev_z_d;
  logic                    primed_q, primed_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    dir_q, dir_d;
  logic                    step_valid_q, step_valid_d;
  logic                    step_err_q, step_err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic signed [POS_W:0]   vel_q, vel_d;
  logic                    vel_valid_q, vel_valid_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic [1:0]              cur_ab;
  step_t                   step;
  logic                    idx_rise;
  logic signed [ACC_W-1:0] contrib;
  logic signed [ACC_W-1:0] acc_sum;

  // Step decode, position/error update and velocity window next-state.
  always_comb begin
    cur_ab       = {a_f, b_f};
    prev_ab_d    = cur_ab;
    prev_z_d     = z_f;
    primed_d     = primed_q | (a_v & b_v & z_v);
    pos_d        = pos_q;
    dir_d        = dir_q;
    step_valid_d = 1'b0;
    step_err_d   = step_err_q;
    err_cnt_d    = err_cnt_q;
    vel_d        = vel_q;
    vel_valid_d  = 1'b0;
    win_d        = win_q;
    acc_d        = acc_q;
    contrib      = '0;

    // Until every filter has locked, the previous-state registers are only primed.
    step     = primed_q ? decode_step(prev_ab_q, cur_ab) : STEP_NONE;
    idx_rise = primed_q & z_f & ~prev_z_q;

    if (clear || idx_rise) begin
      pos_d = '0;
    end else if (step == STEP_FWD) begin
      pos_d        = pos_q + 1'b1;
      dir_d        = 1'b1;
      step_valid_d = 1'b1;
    end else if (step == STEP_REV) begin
      pos_d        = pos_q - 1'b1;
      dir_d        = 1'b0;
      step_valid_d = 1'b1;
    end

    if (step == STEP_ERR) begin
      step_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Velocity counts every decoded step, including ones dropped by clear/index.
    case (step)
      STEP_FWD: contrib = ACC_W'(1);
      STEP_REV: contrib = '1;
      default:  contrib = '0;
    endcase
    acc_sum = acc_q + contrib;

    if (win_q == WIN_LAST) begin
      win_d       = '0;
      acc_d       = '0;
      vel_valid_d = 1'b1;
      if (acc_sum > VEL_MAX)      vel_d = VEL_MAX[POS_W:0];
      else if (acc_sum < VEL_MIN) vel_d = VEL_MIN[POS_W:0];
      else                        vel_d = acc_sum[POS_W:0];
    end else begin
      win_d = win_q + 1'b1;
      acc_d = acc_sum;
    end
  end

  // Decoder state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ab_q    <= 2'b00;
      prev_z_q     <= 1'b0;
      primed_q     <= 1'b0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      step_valid_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_cnt_q    <= 8'd0;
      vel_q        <= '0;
      vel_valid_q  <= 1'b0;
      win_q        <= '0;
      acc_q        <= '0;
    end else begin
      prev_ab_q    <= prev_ab_d;
      prev_z_q     <= prev_z_d;
      primed_q     <= primed_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      step_valid_q <= step_valid_d;
      step_err_q   <= step_err_d;
      err_cnt_q    <= err_cnt_d;
      vel_q        <= vel_d;
      vel_valid_q  <= vel_valid_d;
      win_q        <= win_d;
      acc_q        <= acc_d;
    end
  end

  assign position   = pos_q;
  assign dir        = dir_q;
  assign step_valid = step_valid_q;
  assign step_err   = step_err_q;
  assign err_count  = err_cnt_q;
  assign velocity   = vel_q;
  assign vel_valid  = vel_valid_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Testbench for quadrature_decoder: directed scenarios plus a random walk
// checked against an abstract model (Gray index, modular position, error tally).
module tb_quadrature_decoder;

  localparam int POS_W    = 10;
  localparam int FILT_LEN = 3;
  localparam int VEL_WIN  = 1024;
  localparam int PMOD     = 1 << POS_W;
  // Edges from a change driven after edge E to the output edge: sampled at E+1, updated FILT_LEN+3 later.
  localparam int LAT      = FILT_LEN + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b0, enc_b = 1'b0, enc_z = 1'b0, clear = 1'b0;
  logic [POS_W-1:0]      position;
  logic                  dir, step_valid, step_err, vel_valid;
  logic [7:0]            err_count;
  logic signed [POS_W:0] velocity;

  quadrature_decoder #(.POS_W(POS_W), .FILT_LEN(FILT_LEN), .VEL_WIN(VEL_WIN)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .clear(clear), .position(position), .dir(dir), .step_valid(step_valid),
    .step_err(step_err), .err_count(err_count), .velocity(velocity),
    .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int edge_cnt = 0, sv_count = 0, sv_last_edge = 0;
  int vv_count = 0, vv_last_edge = 0, vel_seen = 0;

  // Pulse monitor: edges counted from reset release, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    if (reset) edge_cnt = 0;
    else begin
      edge_cnt++;
      if (step_valid) begin sv_count++; sv_last_edge = edge_cnt; end
      if (vel_valid) begin vv_count++; vv_last_edge = edge_cnt; vel_seen = int'(velocity); end
    end
  end

  int m_pos = 0, m_dir = 0, m_errs = 0, m_g = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] gray_ab(input int g);
    case (g & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_g();
    {enc_a, enc_b} = gray_ab(m_g);
  endtask

  // kind: 0 forward, 1 reverse, 2 illegal (both channels flip)
  task automatic step_move(input int kind, input int hold);
    case (kind)
      0: begin m_g = (m_g + 1) & 3; m_pos = (m_pos + 1) % PMOD; m_dir = 1; end
      1: begin m_g = (m_g + 3) & 3; m_pos = (m_pos + PMOD - 1) % PMOD; m_dir = 0; end
      default: begin m_g = (m_g + 2) & 3; m_errs++; end
    endcase
    drive_g();
    tick(hold);
  endtask

  task automatic check_state(input string tag);
    chk({tag, " pos"}, int'(position), m_pos);
    chk({tag, " dir"}, int'(dir), m_dir);
    chk({tag, " step_err"}, int'(step_err), (m_errs > 0) ? 1 : 0);
    chk({tag, " err_count"}, int'(err_count), (m_errs > 255) ? 255 : m_errs);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    m_pos = 0; m_dir = 0; m_errs = 0;
    tick(12);
  endtask

  task automatic wait_vel(input int base, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (vv_count > base) ok = 1'b1;
    end
    if (!ok) chk("vel_valid timeout", 0, 1);
  endtask

  initial begin
    int base, e0, r, w, ch;
    m_g = 0;
    drive_g();
    reset = 1'b1;
    tick(4);
    chk("rst position", int'(position), 0);
    chk("rst dir", int'(dir), 0);
    chk("rst step_valid", int'(step_valid), 0);
    chk("rst step_err", int'(step_err), 0);
    chk("rst err_count", int'(err_count), 0);
    chk("rst velocity", int'(velocity), 0);
    chk("rst vel_valid", int'(vel_valid), 0);
    reset = 1'b0;
    tick(12);

    // Velocity over the first window: +20 then -5.
    base = vv_count;
    repeat (20) step_move(0, 10);
    repeat (5) step_move(1, 10);
    check_state("vel walk");
    wait_vel(base, 1500);
    chk("vel1 edge", vv_last_edge, VEL_WIN);
    chk("vel1 value", vel_seen, 15);

    // Reset in the middle of a window discards its steps.
    repeat (3) step_move(0, 10);
    tick(50);
    reset = 1'b1;
    tick(3);
    chk("vel after reset", int'(velocity), 0);
    chk("vel_valid in reset", int'(vel_valid), 0);
    base = vv_count;
    reset = 1'b0;
    m_pos = 0; m_dir = 0; m_errs = 0;
    tick(12);
    repeat (2) step_move(0, 10);
    wait_vel(base, 1500);
    chk("vel2 edge", vv_last_edge, VEL_WIN);
    chk("vel2 value", vel_seen, 2);
    check_state("vel2 walk");

    // Sixteen forward steps.
    do_reset(3);
    base = sv_count;
    repeat (16) step_move(0, 10);
    check_state("fwd16");
    chk("fwd16 pulses", sv_count - base, 16);

    // Wrap both ways.
    do_reset(3);
    step_move(1, 10);
    check_state("wrap down");
    step_move(0, 10);
    check_state("wrap up");

    // Short glitch is discarded; a held level steps with fixed latency.
    base = sv_count;
    enc_a = ~enc_a; tick(FILT_LEN - 1); enc_a = ~enc_a;
    tick(12);
    chk("glitch pulses", sv_count - base, 0);
    check_state("glitch");
    base = sv_count;
    e0 = edge_cnt;
    step_move(0, 12);
    chk("latency pulses", sv_count - base, 1);
    chk("latency edges", sv_last_edge - e0, LAT);
    check_state("latency");

    // Illegal transitions and saturation.
    step_move(2, 10);
    check_state("err1");
    base = sv_count;
    repeat (299) step_move(2, 6);
    tick(10);
    check_state("err300");
    chk("err300 pulses", sv_count - base, 0);

    // Index coinciding with a step, then clear with index, then clear alone.
    do_reset(3);
    repeat (37) step_move(0, 8);
    check_state("pos37");
    enc_z = 1'b1;
    step_move(0, 10);
    m_pos = 0;
    check_state("index+step");
    enc_z = 1'b0;
    tick(10);
    check_state("index fall");
    repeat (3) step_move(0, 10);
    check_state("pre clear+index");
    enc_z = 1'b1;
    tick(LAT - 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(5);
    m_pos = 0;
    check_state("clear+index");
    enc_z = 1'b0;
    tick(10);
    repeat (2) step_move(0, 10);
    clear = 1'b1; tick(1); clear = 1'b0; tick(2);
    m_pos = 0;
    check_state("clear");

    // Reset while a new level is still in the filters: re-prime, no step/error.
    base = sv_count;
    m_g = (m_g + 1) & 3;
    drive_g();
    tick(3);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    m_pos = 0; m_dir = 0; m_errs = 0;
    tick(20);
    check_state("mid reset");
    chk("mid reset pulses", sv_count - base, 0);
    step_move(0, 10);
    check_state("mid reset step");

    // Random walk.
    do_reset(3);
    base = sv_count;
    e0 = 0;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      begin step_move(0, $urandom_range(8, 12)); e0++; end
      else if (r < 8) begin step_move(1, $urandom_range(8, 12)); e0++; end
      else if (r == 8) step_move(2, $urandom_range(8, 12));
      else begin
        ch = $urandom_range(0, 1);
        w  = $urandom_range(1, FILT_LEN - 1);
        if (ch == 1) enc_a = ~enc_a; else enc_b = ~enc_b;
        tick(w);
        if (ch == 1) enc_a = ~enc_a; else enc_b = ~enc_b;
        tick($urandom_range(8, 12));
      end
      check_state($sformatf("rnd%0d", i));
    end
    chk("rnd pulses", sv_count - base, e0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter POS_W, default 10, position counter width (matches encoder_value width).
REQ-002 Parameter FILT_LEN, default 3, consecutive stable cycles required to accept a new input level.
REQ-003 Parameter VEL_WIN, default 1024, velocity measurement window in clk cycles.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enc_a  input  1  encoder channel A, asynchronous to clk.
REQ-007 enc_b  input  1  encoder channel B, asynchronous to clk.
REQ-008 enc_z  input  1  encoder index, asynchronous to clk.
REQ-009 clear  input  1  synchronous position clear.
REQ-010 position  output  POS_W  unsigned joint position count.
REQ-011 dir  output  1  direction of last valid step (1 = forward).
REQ-012 step_valid  output  1  one-cycle pulse on every position change caused by a step.
REQ-013 step_err  output  1  sticky flag: illegal transition seen.
REQ-014 err_count  output  8  saturating count of illegal transitions.
REQ-015 velocity  output  POS_W+1  signed net steps in the last completed window.
REQ-016 vel_valid  output  1  one-cycle pulse when velocity updates.

Function
REQ-017 Each of enc_a, enc_b, enc_z SHALL pass a 2-flop synchronizer and then a glitch filter.
REQ-018 The filtered level SHALL change only after the synchronized level differs from it for FILT_LEN consecutive cycles; a shorter pulse is discarded and restarts the count.
REQ-019 A step SHALL be decoded from previous vs current filtered {A,B}: 00->01->11->10->00 = forward (+1); reverse order = reverse (-1); unchanged = none; both bits changed = error.
REQ-020 Position, dir, step_valid SHALL update on the same edge, exactly FILT_LEN+3 edges after the first edge sampling a new stable input level.
REQ-021 Position SHALL wrap modulo 2^POS_W (max+1 -> 0, 0-1 -> max).
REQ-022 An error step SHALL leave position and dir unchanged, not pulse step_valid, set step_err, and increment err_count saturating at 255.
REQ-023 A filtered enc_z rising edge SHALL load position to 0; clear high SHALL load position to 0.
REQ-024 Priority on the same edge: clear > index > step; a step coinciding with clear/index is dropped from position but still counted for velocity.
REQ-025 A free-running window counter SHALL count 0..VEL_WIN-1; a signed accumulator SHALL sum step contributions (+1/-1).
REQ-026 On the window's last cycle, velocity SHALL load the accumulator including that cycle's step, saturating to signed POS_W+1 range, and vel_valid SHALL pulse; the accumulator restarts at 0.
REQ-027 After reset, the first filtered {A,B} sample SHALL prime the previous-state register without producing a step or error.

Reset
REQ-028 Reset SHALL set position=0, dir=0, step_valid=0, step_err=0, err_count=0, velocity=0, vel_valid=0, window counter and accumulator=0, filter counts=0, prime flag cleared.
REQ-029 Reset asserted mid-transition SHALL discard all in-flight filter state; decoding resumes per REQ-027.
REQ-030 step_err SHALL clear only on reset.

Structure
REQ-031 Package quad_pkg SHALL hold default constants for POS_W, FILT_LEN, VEL_WIN and enum step_t {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR}.
REQ-032 Sub-module quad_input_filter (synchronizer + glitch filter, one bit) SHALL be instanced three times.

Verification
REQ-033 Forward sequence 00,01,11,10 x 4 cycles (16 edges, each held 10 clk) -> position=16, dir=1, 16 step_valid pulses.
REQ-034 From position=0, one reverse step -> position=1023, dir=0; then one forward step -> position=0.
REQ-035 2-cycle glitch on enc_a with FILT_LEN=3 -> no step_valid, position unchanged; 3-cycle level -> exactly one step at FILT_LEN+3 edges.
REQ-036 Force {A,B} 00->11 -> step_err=1, err_count=1, position unchanged; 300 such errors -> err_count=255.
REQ-037 enc_z rising at position=37 coinciding with forward step -> position=0; clear and index together -> position=0.
REQ-038 VEL_WIN=1024, 20 forward then 5 reverse steps inside one window -> vel_valid pulse at window end with velocity=+15; reset mid-window -> velocity=0, next window restarts.
